// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: one access at a time,
// WAIT_STATES wait cycles, RISC-V sub-word stores and sign/zero-extended loads.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_address,
    input  logic [31:0] i_w_data,
    output logic [31:0] o_read_data,
    output logic        o_ready,
    output logic        o_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t        r_state, w_state_next;
    logic [3:0]    r_cnt;
    logic          r_is_load;
    logic [2:0]    r_funct3;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_w_data;
    logic [31:0]   r_read_data;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_req_valid, w_sampling, w_accept, w_enter_resp;
    logic          w_is_load, w_legal, w_misaligned, w_access_ok;
    logic [2:0]    w_funct3;
    logic [AW+1:0] w_addr;
    logic [31:0]   w_wdata, w_word, w_shifted, w_load_val, w_wr_lanes;
    logic [1:0]    w_lane;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic          w_unused_addr;

    assign w_unused_addr = ^i_address[31:AW+2];

    // The edge leaving RESP also samples, so a request can follow straight on.
    assign w_sampling  = (r_state == StIdle) || (r_state == StResp);
    assign w_req_valid = i_mem_read ^ i_mem_write;
    assign w_accept    = w_sampling && w_req_valid;
    assign w_enter_resp = (w_accept && (WAIT_STATES == 0)) ||
                          ((r_state == StWait) && (r_cnt == 4'd0));

    // With no wait states the access completes directly from the request inputs.
    assign w_is_load = w_sampling ? i_mem_read : r_is_load;
    assign w_funct3  = w_sampling ? i_funct3 : r_funct3;
    assign w_addr    = w_sampling ? i_address[AW+1:0] : r_addr;
    assign w_wdata   = w_sampling ? i_w_data : r_w_data;
    assign w_lane    = w_addr[1:0];
    assign w_idx     = w_addr[AW+1:2];

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StResp: begin
                if (w_req_valid) begin
                    w_state_next = (WAIT_STATES == 0) ? StResp : StWait;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StWait:  if (r_cnt == 4'd0) w_state_next = StResp;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_legal = 1'b0;
        case (w_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = w_is_load;
            default:                w_legal = 1'b0;
        endcase
        w_misaligned = ((w_funct3[1:0] == 2'b01) && w_lane[0]) ||
                       ((w_funct3[1:0] == 2'b10) && (w_lane != 2'b00));
        w_access_ok  = w_legal && !w_misaligned;
    end

    always_comb begin
        w_be       = 4'b1111;
        w_wr_lanes = w_wdata;
        case (w_funct3[1:0])
            2'b00: begin
                w_be       = 4'b0001 << w_lane;
                w_wr_lanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be       = 4'b0011 << w_lane;
                w_wr_lanes = {2{w_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_word    = r_mem[w_idx];
    assign w_shifted = w_word >> {w_lane, 3'b000};

    always_comb begin
        case (w_funct3)
            3'b000:  w_load_val = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_val = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_val = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_val = {16'd0, w_shifted[15:0]};
            default: w_load_val = w_shifted;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt       <= 4'd0;
            r_is_load   <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= '0;
            r_w_data    <= 32'd0;
            r_read_data <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_is_load <= i_mem_read;
                r_funct3  <= i_funct3;
                r_addr    <= i_address[AW+1:0];
                r_w_data  <= i_w_data;
                r_cnt     <= CNT_INIT;
            end else if ((r_state == StWait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_err <= !w_access_ok;
                if (w_access_ok && w_is_load) begin
                    r_read_data <= w_load_val;
                end
            end
        end
    end

    // Array is never cleared; a reset in flight suppresses the pending store.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_enter_resp && w_access_ok && !w_is_load) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wr_lanes[8*b +: 8];
            end
        end
    end

    assign o_ready     = (r_state == StResp);
    assign o_err       = o_ready && r_err;
    assign o_read_data = r_read_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (WAIT_STATES=1 and 0) checked
// against a byte-level behavioural model of the memory and the load result.
module tb_dmem_responder;

    localparam int WS1 = 1;
    localparam int WS0 = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd1, wr1, rd0, wr0;
    logic [2:0]  f31, f30;
    logic [31:0] a1, wd1, a0, wd0, rdata1, rdata0;
    logic        rdy1, err1, rdy0, err0;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [2][1024];
    logic [31:0] m_rd [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS1)) dut (
        .i_clk(clk), .i_reset(reset), .i_mem_read(rd1), .i_mem_write(wr1),
        .i_funct3(f31), .i_address(a1), .i_w_data(wd1),
        .o_read_data(rdata1), .o_ready(rdy1), .o_err(err1)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS0)) dut0 (
        .i_clk(clk), .i_reset(reset), .i_mem_read(rd0), .i_mem_write(wr0),
        .i_funct3(f30), .i_address(a0), .i_w_data(wd0),
        .o_read_data(rdata0), .o_ready(rdy0), .o_err(err0)
    );

    // Reference: applies one completed access to the model, returns the expected err.
    function automatic logic model(input int s, input bit rd, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd);
        int  idx;
        int  lane;
        int  nbytes;
        bit  legal;
        bit  sgn;
        logic [31:0] v;
        idx  = int'(a[11:2]);
        lane = int'(a[1:0]);
        nbytes = 4; legal = 0; sgn = 0;
        case (f3)
            3'b000:  begin nbytes = 1; legal = 1;  sgn = 1; end
            3'b001:  begin nbytes = 2; legal = 1;  sgn = 1; end
            3'b010:  begin nbytes = 4; legal = 1;  sgn = 0; end
            3'b100:  begin nbytes = 1; legal = rd; sgn = 0; end
            3'b101:  begin nbytes = 2; legal = rd; sgn = 0; end
            default: legal = 0;
        endcase
        if (lane % nbytes != 0) legal = 0;
        if (!legal) return 1'b1;
        if (rd) begin
            v = 32'd0;
            for (int b = 0; b < nbytes; b++) v[8*b +: 8] = m_mem[s][idx][8*(lane+b) +: 8];
            if (sgn && v[8*nbytes-1]) for (int b = nbytes; b < 4; b++) v[8*b +: 8] = 8'hFF;
            m_rd[s] = v;
        end else begin
            for (int b = 0; b < nbytes; b++) m_mem[s][idx][8*(lane+b) +: 8] = wd[8*b +: 8];
        end
        return 1'b0;
    endfunction

    task automatic drive(input int s, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (s == 1) begin
            rd1 = rd; wr1 = wr; f31 = f3; a1 = a; wd1 = wd;
        end else begin
            rd0 = rd; wr0 = wr; f30 = f3; a0 = a; wd0 = wd;
        end
    endtask

    // Issues one access; lat = edges after the sampling edge until ready is seen (#1 after
    // each edge). RESP begins WAIT_STATES edges after the sampling edge.
    task automatic access(input int s, input bit rd, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic err,
                          output logic [31:0] rdata);
        drive(s, rd, !rd, f3, a, wd);
        @(posedge clk); #1;
        drive(s, 1'b0, 1'b0, 3'b0, 32'd0, 32'd0);
        lat = -1; err = 1'bx; rdata = 'x;
        for (int k = 0; k <= 20; k++) begin
            if ((s == 1) ? rdy1 : rdy0) begin
                lat = k;
                err = (s == 1) ? err1 : err0;
                rdata = (s == 1) ? rdata1 : rdata0;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL ready_timeout s=%0d got no ready required one within 20 edges", s);
        end
    endtask

    function automatic int exp_lat(input int s);
        return (s == 1) ? WS1 : WS0;
    endfunction

    task automatic test_reset();
        int lat; logic err; logic [31:0] rd; logic e;
        reset = 1'b1;
        drive(1, 0, 0, 3'b0, 0, 0);
        drive(0, 0, 0, 3'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        m_rd[0] = 32'd0; m_rd[1] = 32'd0;
        checks++; if (rdata1 !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h required 00000000", rdata1); end
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b required 0", rdy1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err got %b required 0", err1); end
        checks++; if ({rdy0, err0, rdata0} !== 34'd0) begin errors++; $display("FAIL reset_ws0 got %b/%b/%h required 0/0/0", rdy0, err0, rdata0); end
        // Clear the words the bench uses so the model starts from known contents.
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
                e = model(s, 0, 3'b010, 32'(w * 4), 32'd0);
                access(s, 0, 3'b010, 32'(w * 4), 32'd0, lat, err, rd);
            end
        end
        // Store aborted by reset while waiting must not reach the array.
        drive(1, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive(1, 0, 0, 3'b0, 0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_rd[0] = 32'd0; m_rd[1] = 32'd0;
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL abort_ready got %b required 0", rdy1); end
        e = model(1, 1, 3'b010, 32'h10, 32'd0);
        access(1, 1, 3'b010, 32'h10, 32'd0, lat, err, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL abort_load got %h required 00000000", rd); end
        checks++; if (err !== e) begin errors++; $display("FAIL abort_err got %b required %b", err, e); end
    endtask

    task automatic test_basic();
        int lat; logic err; logic [31:0] rd; logic e;
        e = model(1, 0, 3'b010, 32'h20, 32'h12345678);
        access(1, 0, 3'b010, 32'h20, 32'h12345678, lat, err, rd);
        checks++; if (lat != exp_lat(1)) begin errors++; $display("FAIL sw_latency got %0d required %0d", lat, exp_lat(1)); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sw_err got %b required 0", err); end
        e = model(1, 1, 3'b010, 32'h20, 32'd0);
        access(1, 1, 3'b010, 32'h20, 32'd0, lat, err, rd);
        checks++; if (lat != exp_lat(1)) begin errors++; $display("FAIL lw_latency got %0d required %0d", lat, exp_lat(1)); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL lw_data got %h required 12345678", rd); end
        checks++; if (err !== e) begin errors++; $display("FAIL lw_err got %b required %b", err, e); end
        @(posedge clk); #1;
        checks++; if ({rdy1, err1} !== 2'b00) begin errors++; $display("FAIL ready_single_cycle got %b%b required 00", rdy1, err1); end
    endtask

    task automatic test_subword();
        int lat; logic err; logic [31:0] rd; logic e;
        logic [2:0]  f3s  [4] = '{3'b010, 3'b000, 3'b100, 3'b001};
        logic [31:0] adrs [4] = '{32'h20, 32'h21, 32'h21, 32'h22};
        logic [31:0] exps [4] = '{32'h1234AB78, 32'hFFFFFFAB, 32'h000000AB, 32'h00001234};
        e = model(1, 0, 3'b000, 32'h21, 32'h000000AB);
        access(1, 0, 3'b000, 32'h21, 32'h000000AB, lat, err, rd);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sb_err got %b required 0", err); end
        for (int i = 0; i < 4; i++) begin
            e = model(1, 1, f3s[i], adrs[i], 32'd0);
            access(1, 1, f3s[i], adrs[i], 32'd0, lat, err, rd);
            checks++;
            if (rd !== exps[i] || err !== 1'b0) begin
                errors++;
                $display("FAIL subword_load%0d got %h/%b required %h/0", i, rd, err, exps[i]);
            end
        end
    endtask

    task automatic test_errors();
        int lat; logic err; logic [31:0] rd; logic e;
        bit          rds  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] adrs [4] = '{32'h22, 32'h23, 32'h20, 32'h20};
        for (int i = 0; i < 4; i++) begin
            e = model(1, rds[i], f3s[i], adrs[i], 32'hFFFFFFFF);
            access(1, rds[i], f3s[i], adrs[i], 32'hFFFFFFFF, lat, err, rd);
            checks++;
            if (err !== 1'b1 || lat != exp_lat(1) || rd !== 32'h00001234) begin
                errors++;
                $display("FAIL err_access%0d got err=%b lat=%0d data=%h required 1/%0d/00001234",
                         i, err, lat, rd, exp_lat(1));
            end
        end
        e = model(1, 1, 3'b010, 32'h20, 32'd0);
        access(1, 1, 3'b010, 32'h20, 32'd0, lat, err, rd);
        checks++; if (rd !== 32'h1234AB78) begin errors++; $display("FAIL err_array_kept got %h required 1234AB78", rd); end
    endtask

    task automatic test_both_high();
        int lat; logic err; logic [31:0] rd; logic e;
        int seen;
        seen = 0;
        drive(1, 1, 1, 3'b010, 32'h20, 32'h0);
        repeat (5) begin
            @(posedge clk); #1;
            if (rdy1 || err1) seen++;
        end
        drive(1, 0, 0, 3'b0, 0, 0);
        checks++; if (seen != 0) begin errors++; $display("FAIL both_high_ready got %0d pulses required 0", seen); end
        e = model(1, 1, 3'b000, 32'h20, 32'd0);
        access(1, 1, 3'b000, 32'h20, 32'd0, lat, err, rd);
        checks++;
        if (lat != exp_lat(1) || rd !== 32'h00000078) begin
            errors++;
            $display("FAIL both_high_after got lat=%0d data=%h required %0d/00000078", lat, rd, exp_lat(1));
        end
    endtask

    task automatic test_ws0();
        int lat; logic err; logic [31:0] rd; logic e;
        e = model(0, 0, 3'b010, 32'h8, 32'hA5A51234);
        access(0, 0, 3'b010, 32'h8, 32'hA5A51234, lat, err, rd);
        e = model(0, 1, 3'b010, 32'h8, 32'd0);
        access(0, 1, 3'b010, 32'h8, 32'd0, lat, err, rd);
        checks++; if (lat != 0) begin errors++; $display("FAIL ws0_latency got %0d required 0", lat); end
        checks++; if (rd !== 32'hA5A51234) begin errors++; $display("FAIL ws0_lw got %h required A5A51234", rd); end
        e = model(0, 1, 3'b101, 32'hA, 32'd0);
        access(0, 1, 3'b101, 32'hA, 32'd0, lat, err, rd);
        checks++; if (rd !== 32'h0000A5A5) begin errors++; $display("FAIL ws0_lhu got %h required 0000A5A5", rd); end
        e = model(0, 1, 3'b001, 32'hA, 32'd0);
        access(0, 1, 3'b001, 32'hA, 32'd0, lat, err, rd);
        checks++; if (rd !== 32'hFFFFA5A5) begin errors++; $display("FAIL ws0_lh got %h required FFFFA5A5", rd); end
    endtask

    task automatic test_wrap_and_held();
        int lat; logic err; logic [31:0] rd; logic e;
        logic [3:0] pat;
        e = model(1, 0, 3'b010, 32'h00001004, 32'hCAFEF00D);
        access(1, 0, 3'b010, 32'h00001004, 32'hCAFEF00D, lat, err, rd);
        e = model(1, 1, 3'b010, 32'h00000004, 32'd0);
        access(1, 1, 3'b010, 32'h00000004, 32'd0, lat, err, rd);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_load got %h required CAFEF00D", rd); end
        // A request still held at the edge leaving RESP is taken as a second access.
        e = model(1, 1, 3'b000, 32'h5, 32'd0);
        e = model(1, 1, 3'b000, 32'h5, 32'd0);
        drive(1, 1, 0, 3'b000, 32'h5, 32'd0);
        @(posedge clk); #1;
        pat = 4'd0;
        for (int k = 0; k < 4; k++) begin
            pat[k] = rdy1;
            if (k == 3) drive(1, 0, 0, 3'b0, 0, 0);
            else begin @(posedge clk); #1; end
        end
        checks++; if (pat !== 4'b1010) begin errors++; $display("FAIL held_pulses got %b required 1010", pat); end
        checks++; if (rdata1 !== m_rd[1]) begin errors++; $display("FAIL held_data got %h required %h", rdata1, m_rd[1]); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat; logic err; logic [31:0] rd; logic e;
        int s; bit rdn; logic [2:0] f3; logic [31:0] a, wd;
        for (int i = 0; i < 80; i++) begin
            s   = int'($urandom_range(0, 1));
            rdn = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            wd  = $urandom;
            e = model(s, rdn, f3, a, wd);
            access(s, rdn, f3, a, wd, lat, err, rd);
            checks++;
            if (lat != exp_lat(s) || err !== e || rd !== m_rd[s]) begin
                errors++;
                $display("FAIL rand%0d s=%0d rd=%0d f3=%0d a=%h got lat=%0d err=%b data=%h required %0d/%b/%h",
                         i, s, rdn, f3, a, lat, err, rd, exp_lat(s), e, m_rd[s]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_subword();
        test_errors();
        test_both_high();
        test_ws0();
        test_wrap_and_held();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
